// File: rtl/iob_tdp_ram_bist_pkg.sv
// Shared definitions for the true-dual-port RAM BIST: FSM state encoding and
// the base test pattern byte.
package iob_tdp_ram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR_A  = 3'd1,
    ST_RD_B  = 3'd2,
    ST_CHK_B = 3'd3,
    ST_WR_B  = 3'd4,
    ST_RD_A  = 3'd5,
    ST_CHK_A = 3'd6,
    ST_DONE  = 3'd7
  } bist_state_e;

  localparam logic [7:0] PAT_BYTE = 8'hA5;

endpackage

// File: rtl/iob_tdp_ram_bist.sv
// Two-pass BIST for a true-dual-port synchronous RAM: write via A / read via B
// with P(i), then write via B / read via A with ~P(i), comparing every word.
import iob_tdp_ram_bist_pkg::*;

module iob_tdp_ram_bist #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              en_a,
  output logic              we_a,
  output logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] q_a,
  output logic              en_b,
  output logic              we_b,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_b,
  input  logic [DATA_W-1:0] q_b,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ADDR_W+1:0] err_cnt,
  output bist_state_e       state_dbg
);

  localparam int REP = (DATA_W + 7) / 8;
  localparam logic [REP*8-1:0]  PAT_REP = {REP{PAT_BYTE}};
  localparam logic [DATA_W-1:0] PAT_W   = PAT_REP[DATA_W-1:0];

  // P(i): address zero-extended or truncated to the word width, XOR the pattern.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] i);
    return DATA_W'(i) ^ PAT_W;
  endfunction

  bist_state_e       state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              last;
  logic              accept;

  // Compare pipeline: expected word and address of the read issued last cycle.
  logic              chk_v;
  logic              chk_on_a;
  logic [DATA_W-1:0] chk_exp;
  logic [ADDR_W-1:0] chk_addr;
  logic [DATA_W-1:0] q_sel;
  logic              miscmp;

  logic wr_a_n, rd_a_n, wr_b_n, rd_b_n;

  assign last      = &cnt;
  assign accept    = (state == ST_IDLE) && start;
  assign state_dbg = state;
  assign q_sel     = chk_on_a ? q_a : q_b;
  assign miscmp    = chk_v && (q_sel != chk_exp);

  // Valid/ready is not used here: start is a plain request pulse, accepted only
  // in IDLE, and the RAM ports are fire-and-forget with fixed one-cycle latency.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_WR_A;
      ST_WR_A: begin
        cnt_nxt = cnt + 1'b1;
        if (last) state_nxt = ST_RD_B;
      end
      ST_RD_B: begin
        cnt_nxt = cnt + 1'b1;
        if (last) state_nxt = ST_CHK_B;
      end
      ST_CHK_B: state_nxt = ST_WR_B;
      ST_WR_B: begin
        cnt_nxt = cnt + 1'b1;
        if (last) state_nxt = ST_RD_A;
      end
      ST_RD_A: begin
        cnt_nxt = cnt + 1'b1;
        if (last) state_nxt = ST_CHK_A;
      end
      ST_CHK_A: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign wr_a_n = (state_nxt == ST_WR_A);
  assign rd_a_n = (state_nxt == ST_RD_A);
  assign wr_b_n = (state_nxt == ST_WR_B);
  assign rd_b_n = (state_nxt == ST_RD_B);

  // Port outputs are registered from the next state so they line up with the
  // state/counter of the cycle in which they are driven.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      en_a      <= 1'b0;
      we_a      <= 1'b0;
      addr_a    <= '0;
      data_a    <= '0;
      en_b      <= 1'b0;
      we_b      <= 1'b0;
      addr_b    <= '0;
      data_b    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      err_cnt   <= '0;
      chk_v     <= 1'b0;
      chk_on_a  <= 1'b0;
      chk_exp   <= '0;
      chk_addr  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      en_a     <= wr_a_n || rd_a_n;
      we_a     <= wr_a_n;
      addr_a   <= (wr_a_n || rd_a_n) ? cnt_nxt : '0;
      data_a   <= wr_a_n ? pattern(cnt_nxt) : '0;
      en_b     <= wr_b_n || rd_b_n;
      we_b     <= wr_b_n;
      addr_b   <= (wr_b_n || rd_b_n) ? cnt_nxt : '0;
      data_b   <= wr_b_n ? ~pattern(cnt_nxt) : '0;
      busy     <= !((state_nxt == ST_IDLE) || (state_nxt == ST_DONE));
      chk_v    <= (state == ST_RD_B) || (state == ST_RD_A);
      chk_on_a <= (state == ST_RD_A);
      chk_exp  <= (state == ST_RD_A) ? ~pattern(cnt) : pattern(cnt);
      chk_addr <= cnt;
      if (accept) begin
        done      <= 1'b0;
        fail      <= 1'b0;
        fail_addr <= '0;
        err_cnt   <= '0;
      end else begin
        if (state_nxt == ST_DONE) done <= 1'b1;
        if (miscmp) begin
          if (!(&err_cnt)) err_cnt <= err_cnt + 1'b1;
          if (!fail) begin
            fail      <= 1'b1;
            fail_addr <= chk_addr;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_iob_tdp_ram_bist.sv
// Bench for iob_tdp_ram_bist: behavioural dual-port RAM with fault hooks, a
// table of run scenarios, and a hand-written mid-run reset sequence.
import iob_tdp_ram_bist_pkg::*;

module tb_iob_tdp_ram_bist;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int N      = 1 << ADDR_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              en_a, we_a, en_b, we_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] data_a, data_b, q_a, q_b;
  logic              busy, done, fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [ADDR_W+1:0] err_cnt;
  bist_state_e       state_dbg;

  iob_tdp_ram_bist #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .err_cnt(err_cnt), .state_dbg(state_dbg)
  );

  // Behavioural synchronous RAM with fault injection hooks.
  logic [DATA_W-1:0] mem [N];
  logic [DATA_W-1:0] q_a_ram = '0, q_b_ram = '0;
  logic [ADDR_W-1:0] rd_b_addr_d = '0;
  logic              rd_b_v = 1'b0;
  bit                fault_b = 1'b0;
  bit                zero_a  = 1'b0;
  int                wr_cnt  = 0;
  int                overlap = 0;
  int                idle_en = 0;

  always @(posedge clk) begin
    if (en_a) begin
      if (we_a) mem[addr_a] <= data_a;
      q_a_ram <= mem[addr_a];
    end
    if (en_b) begin
      if (we_b) mem[addr_b] <= data_b;
      q_b_ram <= mem[addr_b];
    end
    rd_b_v      <= en_b && !we_b;
    rd_b_addr_d <= addr_b;
    wr_cnt      <= wr_cnt + int'(en_a && we_a) + int'(en_b && we_b);
  end

  assign q_a = zero_a ? '0 : q_a_ram;
  assign q_b = q_b_ram ^ {7'b0, fault_b && rd_b_v && (rd_b_addr_d == 4'd3)};

  always @(negedge clk) begin
    if ((en_a || we_a) && (en_b || we_b)) overlap++;
    if ((en_a || en_b) && (state_dbg == ST_IDLE || state_dbg == ST_DONE ||
                           state_dbg == ST_CHK_A || state_dbg == ST_CHK_B)) idle_en++;
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string nm, input logic [63:0] act);
    logic [63:0] exp;
    exp = exp_q.pop_front();
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] outs_all();
    return 64'({en_a, we_a, en_b, we_b, busy, done, fail, fail_addr, err_cnt,
                addr_a, addr_b, data_a, data_b, state_dbg});
  endfunction

  typedef struct {
    string      name;
    bit         fault_b;
    bit         zero_a;
    bit         restart;
    int         exp_cycles;
    bit         exp_fail;
    logic [3:0] exp_fail_addr;
    logic [5:0] exp_err;
  } vec_t;

  vec_t vecs[5];

  // driver: one full run with the scenario's fault knobs, then result checks
  task automatic run_vec(input vec_t v);
    int cycles;
    int guard;
    int wc0;
    fault_b = v.fault_b;
    zero_a  = v.zero_a;
    wc0     = wr_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back(64'h1); check({v.name, "_accept_busy"}, 64'(busy));
    exp_q.push_back(64'h0); check({v.name, "_accept_clear"}, 64'({done, fail, err_cnt}));
    cycles = 1;
    guard  = 0;
    while (busy && guard < 200) begin
      start = (v.restart && cycles == 10);
      @(negedge clk);
      guard++;
      if (busy) cycles++;
    end
    start = 1'b0;
    exp_q.push_back(64'h0); check({v.name, "_timeout"}, 64'(busy));
    exp_q.push_back(64'(v.exp_cycles)); check({v.name, "_busy_len"}, 64'(cycles));
    exp_q.push_back(64'(ST_DONE)); check({v.name, "_state_done"}, 64'(state_dbg));
    exp_q.push_back(64'h1); check({v.name, "_done"}, 64'(done));
    exp_q.push_back(64'(v.exp_fail)); check({v.name, "_fail"}, 64'(fail));
    exp_q.push_back(64'(v.exp_fail_addr)); check({v.name, "_fail_addr"}, 64'(fail_addr));
    exp_q.push_back(64'(v.exp_err)); check({v.name, "_err_cnt"}, 64'(err_cnt));
    exp_q.push_back(64'(2 * N)); check({v.name, "_writes"}, 64'(wr_cnt - wc0));
    exp_q.push_back(64'h5A); check({v.name, "_mem0"}, 64'(mem[0]));
    exp_q.push_back(64'h55); check({v.name, "_mem15"}, 64'(mem[15]));
    @(negedge clk);
    exp_q.push_back(64'(ST_IDLE)); check({v.name, "_back_idle"}, 64'(state_dbg));
    exp_q.push_back(64'h1); check({v.name, "_done_sticky"}, 64'(done));
    fault_b = 1'b0;
    zero_a  = 1'b0;
  endtask

  initial begin
    int guard;
    int wc_rst;
    vecs[0] = '{"clean",    0, 0, 0, 4*N+2, 0, 4'd0, 6'd0};
    vecs[1] = '{"flip_b3",  1, 0, 0, 4*N+2, 1, 4'd3, 6'd1};
    vecs[2] = '{"qa_zero",  0, 1, 0, 4*N+2, 1, 4'd0, 6'd16};
    vecs[3] = '{"restart",  0, 0, 1, 4*N+2, 0, 4'd0, 6'd0};
    vecs[4] = '{"clean2",   0, 0, 0, 4*N+2, 0, 4'd0, 6'd0};

    for (int i = 0; i < N; i++) mem[i] = '0;

    repeat (3) @(negedge clk);
    exp_q.push_back(64'h0); check("reset_outputs", outs_all());
    rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(64'(ST_IDLE)); check("idle_wait", 64'(state_dbg));

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // reset asserted in WR_B at i=5
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(state_dbg == ST_WR_B && addr_b == 4'd5) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    exp_q.push_back(64'h1); check("reach_wr_b5", 64'(state_dbg == ST_WR_B && addr_b == 4'd5));
    rst = 1'b1;
    #1;
    exp_q.push_back(64'h0); check("midrun_reset_outputs", outs_all());
    wc_rst = wr_cnt;
    repeat (3) @(negedge clk);
    exp_q.push_back(64'(wc_rst)); check("no_write_in_reset", 64'(wr_cnt));
    rst = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back(64'h0); check("post_reset_idle", 64'({busy, done, state_dbg}));
    run_vec(vecs[0]);

    exp_q.push_back(64'h0); check("port_overlap", 64'(overlap));
    exp_q.push_back(64'h0); check("port_en_outside_rw", 64'(idle_en));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
